// File: rtl/div_pkg.sv
// div_sched shared definitions: FSM encoding, operand width and nominal
// gnt-to-done latency of a divider operation.
package div_pkg;

  localparam int unsigned W           = 32;
  localparam int unsigned DIV_LATENCY = 36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_sched_if.sv
// Requester-side bus of div_sched: packed per-requester operands, grant and
// completion pulses, shared result.
interface div_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = div_pkg::W
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a;
  logic [NREQ*W-1:0] b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      q;
  logic [W-1:0]      r;
  logic              err;
  logic              busy;

  modport master (output req, a, b, input gnt, done, q, r, err, busy);
  modport slave  (input req, a, b, output gnt, done, q, r, err, busy);

endinterface

// File: rtl/div_rr_arb.sv
// Round-robin arbiter: the search starts one position past the last
// granted requester and wraps, so a lone requester always wins.
module div_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [IW-1:0] j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = IW'((32'(last) + k) % NREQ);
      if (!any && req[j]) begin
        any     = 1'b1;
        win_idx = j;
      end
    end
    win[win_idx] = any;
  end

endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one 32-bit divider among NREQ
// requesters. Build macro DIV_SCHED_ZERO_BYPASS_EN answers b==0 locally.
module div_sched
  import div_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = div_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  div_sched_if.slave   bus,
  output logic         div_start,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic         div_ok,
  input  logic         div_err,
  input  logic [W-1:0] div_d,
  input  logic [W-1:0] div_r
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nx;
  logic [IW-1:0]   last, idx, win_idx;
  logic [NREQ-1:0] win, gnt, done;
  logic            any, seen_busy, err;
  logic [W-1:0]    a_sel, b_sel, q, r;
  logic            issue_div, zero_hold;
  logic [W-1:0]    cap_q, cap_r;
  logic            cap_err;

  div_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (bus.req),
    .last    (last),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign a_sel = bus.a[win_idx*W +: W];
  assign b_sel = bus.b[win_idx*W +: W];

`ifdef DIV_SCHED_ZERO_BYPASS_EN
  assign issue_div = (b_sel != '0);
  // A bypassed op dwells two cycles in CAPT; seen_busy marks the second one.
  assign zero_hold = (div_b == '0) && !seen_busy;
  assign cap_q     = (div_b == '0) ? '1 : div_d;
  assign cap_r     = (div_b == '0) ? div_a : div_r;
  assign cap_err   = (div_b == '0) ? 1'b1 : div_err;
`else
  assign issue_div = 1'b1;
  assign zero_hold = 1'b0;
  assign cap_q     = div_d;
  assign cap_r     = div_r;
  assign cap_err   = div_err;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any) state_nx = issue_div ? RUN : CAPT;
      RUN:     if (div_ok && seen_busy) state_nx = CAPT;
      CAPT:    if (!zero_hold) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      div_start <= 1'b0;
      err       <= 1'b0;
      q         <= '0;
      r         <= '0;
      div_a     <= '0;
      div_b     <= '0;
      idx       <= '0;
      last      <= IW'(NREQ - 1);
      seen_busy <= 1'b0;
    end else begin
      state <= state_nx;
      gnt   <= '0;
      done  <= '0;
      unique case (state)
        IDLE: if (any) begin
          gnt       <= win;
          div_a     <= a_sel;
          div_b     <= b_sel;
          idx       <= win_idx;
          last      <= win_idx;
          div_start <= issue_div;
        end
        RUN: if (!div_ok) seen_busy <= 1'b1;
        CAPT: begin
          if (zero_hold) begin
            seen_busy <= 1'b1;
          end else begin
            q         <= cap_q;
            r         <= cap_r;
            err       <= cap_err;
            div_start <= 1'b0;
            done[idx] <= 1'b1;
          end
        end
        DONE: seen_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.gnt  = gnt;
  assign bus.done = done;
  assign bus.q    = q;
  assign bus.r    = r;
  assign bus.err  = err;
  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: behavioural divider, round-robin
// reference model, directed and randomized request sequences.
`timescale 1ns/1ps
module tb_div_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;
  localparam int          LAT  = 36;
  // Busy time of the modelled divider; scheduler overhead makes gnt->done 36.
  localparam int unsigned DIV_BUSY = 33;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  logic         div_start, div_ok, div_err;
  logic [W-1:0] div_a, div_b, div_d, div_r;

  div_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_ok    (div_ok),
    .div_err   (div_err),
    .div_d     (div_d),
    .div_r     (div_r)
  );

  // Divider: ok drops after start is seen, returns with the result later.
  int unsigned dcnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_ok <= 1'b1; dcnt <= 0; div_err <= 1'b0; div_d <= '0; div_r <= '0;
    end else if (!div_start) begin
      div_ok <= 1'b1; dcnt <= 0;
    end else if (dcnt == 0 && div_ok) begin
      div_ok <= 1'b0; dcnt <= 1;
    end else if (!div_ok) begin
      if (dcnt == DIV_BUSY) begin
        div_ok  <= 1'b1;
        div_err <= (div_b == '0);
        div_d   <= (div_b == '0) ? '1 : div_a / div_b;
        div_r   <= (div_b == '0) ? div_a : div_a % div_b;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  int ndone = 0;
  always @(negedge clk) if (bus.done != '0) ndone++;

  int n_cmp = 0;
  int n_bad = 0;

  logic [NREQ-1:0] rq;
  logic [W-1:0]    opa [NREQ];
  logic [W-1:0]    opb [NREQ];
  int              m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  task automatic drive();
    bus.req = rq;
    for (int i = 0; i < NREQ; i++) begin
      bus.a[i*W +: W] = opa[i];
      bus.b[i*W +: W] = opb[i];
    end
  endtask

  task automatic raise(input int i, input logic [W-1:0] av, input logic [W-1:0] bv);
    opa[i] = av; opb[i] = bv; rq[i] = 1'b1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_start"}, div_start, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_q"}, bus.q, 0);
    chk({tag, "_r"}, bus.r, 0);
    chk({tag, "_div_a"}, div_a, 0);
    chk({tag, "_div_b"}, div_b, 0);
  endtask

  // One operation: wait for grant, check winner, then completion and result.
  task automatic serve(input logic [NREQ-1:0] keep, input logic [NREQ-1:0] clr,
                       input logic [NREQ-1:0] glitch, output int who, output int gwait);
    int n, exp_w, elat;
    logic [W-1:0] ea, eb, eq, er;
    logic ee, exp_start;
    exp_w = rr_pick(rq, m_last);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 3*div_pkg::DIV_LATENCY);
    gwait = n;
    chk("gnt_seen", 64'(bus.gnt != '0), 64'd1);
    if (bus.gnt == '0) begin summary(); $fatal(1, "no grant within bound"); end
    chk("gnt_winner", bus.gnt, 1 << exp_w);
    who = exp_w;
    for (int i = 0; i < NREQ; i++) if (bus.gnt == (1 << i)) who = i;
    m_last = exp_w;
    ea = opa[exp_w]; eb = opb[exp_w];
    if (eb == '0) begin eq = '1; er = ea; ee = 1'b1; end
    else begin eq = ea / eb; er = ea % eb; ee = 1'b0; end
`ifdef DIV_SCHED_ZERO_BYPASS_EN
    elat = (eb == '0) ? 2 : LAT;
    exp_start = (eb != '0);
`else
    elat = LAT;
    exp_start = 1'b1;
`endif
    if (!keep[exp_w]) rq[exp_w] = 1'b0;
    rq &= ~clr;
    opa[exp_w] = $urandom;
    opb[exp_w] = $urandom_range(1, 5000);
    drive();
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        chk("gnt_pulse", bus.gnt, 0);
        chk("busy_run", bus.busy, 1);
        chk("start_run", div_start, exp_start);
      end
      if (glitch != '0 && n == 3) begin rq |= glitch; drive(); end
      if (glitch != '0 && n == 6) begin rq &= ~glitch; drive(); end
    end while (bus.done == '0 && n < 3*div_pkg::DIV_LATENCY);
    chk("latency", n, elat);
    chk("done_idx", bus.done, 1 << exp_w);
    chk("q", bus.q, eq);
    chk("r", bus.r, er);
    chk("err", bus.err, ee);
    chk("start_low0", div_start, 0);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("q_hold", bus.q, eq);
    chk("start_low1", div_start, 0);
  endtask

  initial begin
    int who, gw, n, nd0, maxw;
    int wt [NREQ];
    logic [NREQ-1:0] m;
    logic [W-1:0] bv;

    rq = '0;
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = 32'd1; wt[i] = 0; end
    m_last = NREQ - 1;

    // Reset with all requesters already asserting.
    for (int i = 0; i < NREQ; i++) raise(i, 32'd1000 + 32'(i), 32'd3 + 32'(i));
    drive();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    reset = 1'b1;

    // Contention: 0,1,2,3,0 with back-to-back issue.
    for (int k = 0; k < 5; k++) begin
      serve((k < 4) ? '1 : '0, (k < 4) ? '0 : '1, '0, who, gw);
      chk("rr_order", who, k % NREQ);
      chk("b2b_gap", gw, 1);
    end

    // Single request 100/7 on requester 1.
    raise(1, 32'd100, 32'd7); drive();
    serve('0, '0, '0, who, gw);

    // Zero divisor 55/0 on requester 0.
    raise(0, 32'd55, 32'd0); drive();
    serve('0, '0, '0, who, gw);

    // Requester 3 pulses req only while an op is in flight: ignored.
    opa[3] = 32'd9; opb[3] = 32'd3;
    raise(2, 32'd77, 32'd5); drive();
    serve('0, '0, 4'b1000, who, gw);
    repeat (6) @(negedge clk);
    chk("ignored_req_busy", bus.busy, 0);

    // Reset 10 cycles into RUN abandons the op.
    raise(1, 32'd123, 32'd4); drive();
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 10);
    chk("rst_gnt_seen", 64'(bus.gnt != '0), 64'd1);
    rq = '0; drive();
    repeat (10) @(negedge clk);
    chk("rst_busy_before", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk_idle_zero("midop_reset");
    nd0 = ndone;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_last = NREQ - 1;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", ndone, nd0);
    raise(2, 32'd1000, 32'd10); drive();
    serve('0, '0, '0, who, gw);

    // Fairness: req[2] held, req[0] raised every other operation.
    maxw = 0;
    rq = '0; wt[0] = 0; wt[2] = 0;
    raise(2, 32'd500, 32'd9);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0 && !rq[0]) begin raise(0, $urandom, $urandom_range(1, 99)); wt[0] = 0; end
      drive();
      serve(4'b0100, (k == 7) ? '1 : '0, '0, who, gw);
      if (wt[who] > maxw) maxw = wt[who];
      wt[who] = 0;
      for (int i = 0; i < NREQ; i++) if (i != who && (rq[i] || (k == 7 && i == 2))) wt[i]++;
    end
    chk("fair_max_wait", 64'(maxw <= NREQ), 64'd1);

    // Randomized mix of requesters and operands, including zero divisors.
    for (int k = 0; k < 24; k++) begin
      m = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (m[i] && !rq[i]) begin
          bv = ($urandom_range(0, 5) == 0) ? '0 :
               ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(1, 20));
          raise(i, $urandom, bv);
        end
      end
      if (rq == '0) raise($urandom_range(0, NREQ - 1), $urandom, $urandom_range(1, 1000));
      drive();
      serve('0, (k == 23) ? '1 : '0, '0, who, gw);
    end

    summary();
    $finish;
  end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one 32-bit divider (legal values 2..8).
REQ-002 The block SHALL have parameter W, default 32, meaning the operand width, fixed to 32 to match the divider.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, and release is synchronous to clk.
REQ-005 req  input  NREQ  per-requester request; held high with operands stable until gnt.
REQ-006 a  input  NREQ*W  dividends, packed; requester i uses a[i*W +: W].
REQ-007 b  input  NREQ*W  divisors, packed as for a.
REQ-008 gnt  output  NREQ  one-hot, one-cycle pulse: operands of that requester captured.
REQ-009 done  output  NREQ  one-hot, one-cycle pulse: q/r/err valid for that requester.
REQ-010 q, r  output  W  quotient and remainder; valid only in the cycle done is high; hold their value otherwise.
REQ-011 err  output  1  divide-by-zero flag, qualified by done.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 div_start  output  1  start to the divider; a low level clears the divider.
REQ-014 div_a, div_b  output  W  latched operands to the divider.
REQ-015 div_ok, div_err  input  1  divider ready and divide-by-zero indications.
REQ-016 div_d, div_r  input  W  divider quotient and remainder.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, CAPT and DONE, encoded in 2 bits.
REQ-018 IDLE with any req: the block SHALL pulse the arbiter winner's gnt for one cycle, latch its operands into div_a/div_b, store its index, and go to RUN; with no req it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: priority starts at (last granted index + 1) mod NREQ; a lone requester SHALL be granted every time.
REQ-020 RUN SHALL hold div_start=1, set a seen_busy flag when div_ok=0, and go to CAPT on the first div_ok=1 after seen_busy.
REQ-021 CAPT SHALL register div_d, div_r and div_err into q, r and err, drop div_start to 0, and go to DONE.
REQ-022 DONE SHALL pulse done[index] for one cycle, keep div_start=0, clear seen_busy, and return to IDLE.
REQ-023 div_start SHALL be low for at least 2 cycles between consecutive operations so the divider fully clears.
REQ-024 Latency from gnt to done SHALL be 36 cycles for a nonzero divisor; back-to-back issue SHALL be possible one cycle after done.
REQ-025 A req that drops before gnt SHALL be ignored; a req held after done SHALL re-arbitrate normally.
REQ-026 Changes to req or operands during RUN/CAPT/DONE SHALL NOT affect the operation in flight.

Reset
REQ-027 While reset=0: state=IDLE; gnt, done, busy, div_start, err = 0; q, r, div_a, div_b = 0; last-granted pointer = NREQ-1 (requester 0 has first priority).
REQ-028 A reset mid-operation SHALL abandon the operation with no done pulse; the driven div_start=0 clears the divider.

Configuration
REQ-029 The block SHALL support macro DIV_SCHED_ZERO_BYPASS_EN.
- Defined: a granted b==0 SHALL skip RUN and go straight to CAPT with q=all-ones, r=a, err=1; gnt-to-done latency is 2 cycles and div_start stays 0.
- Undefined: b==0 SHALL be issued to the divider like any other divisor, with err taken from div_err.

Structure
REQ-030 The FSM state encoding, W, and the 36-cycle latency constant SHALL live in shared package div_pkg.
REQ-031 Round-robin selection SHALL be a sub-module, div_rr_arb (inputs: req and a last-granted pointer; outputs: one-hot winner, winner index, any).

Verification
REQ-032 Single request: requester 1 with a=100, b=7 -> gnt[1] one cycle, then done[1] 36 cycles later with q=14, r=2, err=0.
REQ-033 Contention: req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0; each done precedes the next gnt.
REQ-034 Zero divisor: a=55, b=0 -> with macro, done in 2 cycles with q=32'hFFFFFFFF, r=55, err=1; without macro, err=1 from the divider and 36-cycle latency.
REQ-035 Reset pulse 10 cycles into RUN -> all outputs 0, no done pulse; the next request after release completes correctly (a=1000, b=10 -> q=100, r=0).
REQ-036 Fairness: req[2] held constantly and req[0] asserted every other operation -> neither requester waits more than NREQ grants.
